// File: rtl/half_adder_resp_checker.sv
// Response checker for a half adder: compares sampled sum/carry against a^b / a&b
// over a run of EXP_VECTORS accepted samples and reports counts and the first failure.
module half_adder_resp_checker #(
    parameter int EXP_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_sum,
    input  logic             in_carry,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       first_fail,
    output logic [CNT_W-1:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] EXP_N   = CNT_W'(EXP_VECTORS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             accept;
    logic             mismatch;
    logic [CNT_W-1:0] vec_nxt;

    assign accept   = (state == RUN) && in_valid;
    assign mismatch = (in_sum != (in_a ^ in_b)) || (in_carry != (in_a & in_b));
    assign vec_nxt  = vec_cnt + CNT_W'(1);

    // Status flags decode straight from the state register, so they are glitch-free
    // and drop to 0 the moment reset asserts.
    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign pass     = done && (err_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        vec_cnt        <= '0;
                        err_cnt        <= '0;
                        first_fail     <= '0;
                        first_fail_idx <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        vec_cnt <= vec_nxt;
                        if (mismatch) begin
                            if (err_cnt != CNT_MAX)
                                err_cnt <= err_cnt + CNT_W'(1);
                            // err_cnt is cleared on run entry, so zero marks the first miss
                            if (err_cnt == '0) begin
                                first_fail     <= {in_a, in_b, in_sum, in_carry};
                                first_fail_idx <= vec_cnt;
                            end
                        end
                        if (vec_nxt == EXP_N)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
